// File: rtl/load_store_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit_if : request/response and data-memory signals of the LSU
// Revision 1.0
// ---------------------------------------------------------------------------
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] load_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, funct3, addr, store_data, mem_rdata,
    output req_ready, resp_valid, resp_err, load_data,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, funct3, addr, store_data, mem_rdata,
    input  req_ready, resp_valid, resp_err, load_data,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit : RV32I byte-addressed load/store onto a word-indexed memory
// Revision 1.0
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int WORD_AW    = 5,
  parameter bit ADDR_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        wr_q, wr_d;
  logic [15:0] sdata_q, sdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        f3_bad, misaligned, out_of_range, req_err;
  logic [31:0] rd_shift, load_ext, merged;

  always_comb begin
    f3_bad = 1'b1;
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
      3'b100, 3'b101:         f3_bad = bus.req_write;
      default:                f3_bad = 1'b1;
    endcase
    misaligned   = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                   ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    out_of_range = ADDR_CHECK && ((bus.addr >> (WORD_AW + 2)) != 32'd0);
    req_err      = f3_bad || misaligned || out_of_range;
  end

  // Load lane extraction works directly on the live read data of the RD cycle
  always_comb begin
    rd_shift = bus.mem_rdata >> {off_q, 3'b000};
    load_ext = bus.mem_rdata;
    case (f3_q)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'd0, rd_shift[7:0]};
      3'b101:  load_ext = {16'd0, rd_shift[15:0]};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    merged = rdata_q;
    if (f3_q[0]) begin
      if (off_q[1]) merged[31:16] = sdata_q;
      else          merged[15:0]  = sdata_q;
    end else begin
      case (off_q)
        2'd0:    merged[7:0]   = sdata_q[7:0];
        2'd1:    merged[15:8]  = sdata_q[7:0];
        2'd2:    merged[23:16] = sdata_q[7:0];
        default: merged[31:24] = sdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    f3_d        = f3_q;
    wr_d        = wr_q;
    sdata_d     = sdata_q;
    rdata_d     = rdata_q;
    load_data_d = load_data_q;
    resp_err_d  = resp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          off_d      = bus.addr[1:0];
          f3_d       = bus.funct3;
          wr_d       = bus.req_write;
          sdata_d    = bus.store_data[15:0];
          mem_addr_d = 32'(bus.addr[WORD_AW+1:2]);
          if (req_err) begin
            state_d    = S_DONE;
            resp_err_d = 1'b1;
          end else if (bus.req_write && (bus.funct3 == 3'b010)) begin
            state_d     = S_WR;
            mem_wdata_d = bus.store_data;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        rdata_d = bus.mem_rdata;
        if (wr_q) begin
          state_d = S_MERGE;
        end else begin
          state_d     = S_DONE;
          resp_err_d  = 1'b0;
          load_data_d = load_ext;
        end
      end
      S_MERGE: begin
        mem_wdata_d = merged;
        state_d     = S_WR;
      end
      S_WR: begin
        state_d    = S_DONE;
        resp_err_d = 1'b0;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      wr_q        <= 1'b0;
      sdata_q     <= 16'd0;
      rdata_q     <= 32'd0;
      load_data_q <= 32'd0;
      resp_err_q  <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      wr_q        <= wr_d;
      sdata_q     <= sdata_d;
      rdata_q     <= rdata_d;
      load_data_q <= load_data_d;
      resp_err_q  <= resp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_err   = resp_err_q;
  assign bus.load_data  = load_data_q;
  assign bus.mem_read   = (state_q == S_RD);
  // A reset arriving during WR must not let the write commit on that edge
  assign bus.mem_write  = (state_q == S_WR) && !rst;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_load_store_unit : directed and random checks against a behavioural model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_load_store_unit;
  localparam int WORDS = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  load_store_unit #(.WORD_AW(5), .ADDR_CHECK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // data_memory: async read, sync write, plus a backdoor port for preloading
  logic [31:0] mem [WORDS];
  logic        bd_we;
  logic [4:0]  bd_idx;
  logic [31:0] bd_dat;
  assign bus.mem_rdata = mem[bus.mem_addr[4:0]];
  always @(posedge clk) begin
    if (bd_we)              mem[bd_idx] <= bd_dat;
    else if (bus.mem_write) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
  end

  logic [31:0] ref_mem [WORDS];
  logic [31:0] exp_ld;
  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input int idx, input logic [31:0] v);
    @(negedge clk);
    bd_we  = 1'b1;
    bd_idx = idx[4:0];
    bd_dat = v;
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_mem[idx] = v;
  endtask

  // Reference: applies one request to ref_mem and predicts the response
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic e_err, output int e_lat,
                       output int e_rd, output int e_wr);
    int nb, sh, idx;
    logic [31:0] mask, word, val;
    bit ok;
    if (wr) ok = (f3 inside {3'b000, 3'b001, 3'b010});
    else    ok = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    nb    = 1 << f3[1:0];
    e_err = !ok || ((a % nb) != 0) || (a >= 4 * WORDS);
    e_lat = 1; e_rd = 0; e_wr = 0;
    if (e_err) return;
    idx  = int'(a / 4);
    sh   = int'(8 * (a % 4));
    word = ref_mem[idx];
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    if (!wr) begin
      val = (word >> sh) & mask;
      if (!f3[2] && nb < 4 && val[8*nb-1]) val = val | ~mask;
      exp_ld = val;
      e_lat = 2; e_rd = 1;
    end else if (nb == 4) begin
      ref_mem[idx] = d;
      e_lat = 2; e_wr = 1;
    end else begin
      ref_mem[idx] = (word & ~(mask << sh)) | ((d & mask) << sh);
      e_lat = 4; e_rd = 1; e_wr = 1;
    end
  endtask

  task automatic run_op(input string name, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] ld_obs, output logic err_obs);
    logic e_err;
    int e_lat, e_rd, e_wr;
    int cyc, lat, n_rd, n_wr, n_both;
    logic addr_bad;
    model(wr, f3, a, d, e_err, e_lat, e_rd, e_wr);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.funct3 = f3;
    bus.addr = a; bus.store_data = d;
    check($sformatf("%s ready", name), 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble request inputs so the DUT must rely on what it latched
    bus.req_valid = 1'b0; bus.req_write = ~wr; bus.funct3 = 3'($urandom);
    bus.addr = $urandom; bus.store_data = $urandom;
    cyc = 0; lat = 0; n_rd = 0; n_wr = 0; n_both = 0; addr_bad = 1'b0;
    ld_obs = 32'hx; err_obs = 1'bx;
    while (lat == 0 && cyc < 12) begin
      cyc++;
      if (bus.mem_read)  n_rd++;
      if (bus.mem_write) n_wr++;
      if (bus.mem_read && bus.mem_write) n_both++;
      if ((bus.mem_read || bus.mem_write) && bus.mem_addr !== {27'd0, a[6:2]}) addr_bad = 1'b1;
      if (bus.resp_valid) begin
        lat = cyc; err_obs = bus.resp_err; ld_obs = bus.load_data;
      end
      @(posedge clk);
      #1;
    end
    check($sformatf("%s latency", name), 32'(lat), 32'(e_lat));
    check($sformatf("%s resp_err", name), 32'(err_obs), 32'(e_err));
    check($sformatf("%s read_cycles", name), 32'(n_rd), 32'(e_rd));
    check($sformatf("%s write_cycles", name), 32'(n_wr), 32'(e_wr));
    check($sformatf("%s rd_wr_overlap", name), 32'(n_both), 32'd0);
    check($sformatf("%s mem_addr", name), 32'(addr_bad), 32'd0);
    check($sformatf("%s resp_pulse_end", name), 32'(bus.resp_valid), 32'd0);
    if (!e_err) begin
      check($sformatf("%s load_data", name), ld_obs, exp_ld);
      check($sformatf("%s mem_word", name), mem[a[6:2]], ref_mem[a[6:2]]);
    end
  endtask

  logic [31:0] ld;
  logic        er;
  logic        e_err1;
  int          l1, r1, w1;
  logic [31:0] exp1, exp2;
  int          pulses, acc_cycle;
  logic        second_acc, acc_now;

  initial begin
    checks = 0; errors = 0; exp_ld = 32'd0;
    rst = 1'b1; bd_we = 1'b0; bd_idx = 5'd0; bd_dat = 32'd0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.funct3 = 3'd0;
    bus.addr = 32'd0; bus.store_data = 32'd0;
    for (int i = 0; i < WORDS; i++) bd_write(i, $urandom);
    @(posedge clk);
    #1 rst = 1'b0;
    check("reset req_ready",  32'(bus.req_ready), 32'd1);
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_err",   32'(bus.resp_err), 32'd0);
    check("reset load_data",  bus.load_data, 32'd0);
    check("reset mem_read",   32'(bus.mem_read), 32'd0);
    check("reset mem_write",  32'(bus.mem_write), 32'd0);
    check("reset mem_addr",   bus.mem_addr, 32'd0);
    check("reset mem_wdata",  bus.mem_wdata, 32'd0);

    // Loads with sign/zero extension
    bd_write(3, 32'h804020F1);
    run_op("t1_lb", 1'b0, 3'b000, 32'h0C, 32'd0, ld, er);
    check("t1_lb value", ld, 32'hFFFFFFF1);
    run_op("t1_lbu", 1'b0, 3'b100, 32'h0C, 32'd0, ld, er);
    check("t1_lbu value", ld, 32'h000000F1);
    run_op("t1_lh", 1'b0, 3'b001, 32'h0E, 32'd0, ld, er);
    check("t1_lh value", ld, 32'hFFFF8040);
    run_op("t1_lhu", 1'b0, 3'b101, 32'h0E, 32'd0, ld, er);
    check("t1_lhu value", ld, 32'h00008040);

    // Sub-word and full-word stores
    bd_write(3, 32'h11223344);
    run_op("t2_sb", 1'b1, 3'b000, 32'h0D, 32'h000000AA, ld, er);
    check("t2_sb word", mem[3], 32'h1122AA44);
    run_op("t3_sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, ld, er);
    check("t3_sw word", mem[4], 32'hDEADBEEF);

    // Error cases
    run_op("t4_lw_mis", 1'b0, 3'b010, 32'h06, 32'd0, ld, er);
    check("t4_lw_mis err", 32'(er), 32'd1);
    run_op("t4_sh_mis", 1'b1, 3'b001, 32'h03, 32'h1234, ld, er);
    check("t4_sh_mis err", 32'(er), 32'd1);
    run_op("t4_f3_011", 1'b0, 3'b011, 32'h00, 32'd0, ld, er);
    check("t4_f3_011 err", 32'(er), 32'd1);
    run_op("t4_st_bu", 1'b1, 3'b100, 32'h00, 32'd0, ld, er);
    run_op("t4_range", 1'b0, 3'b010, 32'h80, 32'd0, ld, er);
    check("t4_range err", 32'(er), 32'd1);

    // Reset during the write cycle of an SH
    bd_write(2, 32'h13579BDF);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.funct3 = 3'b001;
    bus.addr = 32'h08; bus.store_data = 32'h0000BEEF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("t5 write_active", 32'(bus.mem_write), 32'd1);
    check("t5 wdata", bus.mem_wdata, 32'h1357BEEF);
    rst = 1'b1;
    #1;
    check("t5 write_gated", 32'(bus.mem_write), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_ld = 32'd0;
    check("t5 no_resp", 32'(bus.resp_valid), 32'd0);
    check("t5 ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("t5 no_resp_late", 32'(bus.resp_valid), 32'd0);
    check("t5 word", mem[2], 32'h13579BDF);

    // Back-to-back loads with req_valid held high
    bd_write(1, $urandom);
    bd_write(2, $urandom);
    model(1'b0, 3'b010, 32'h04, 32'd0, e_err1, l1, r1, w1);
    exp1 = exp_ld;
    model(1'b0, 3'b000, 32'h08, 32'd0, e_err1, l1, r1, w1);
    exp2 = exp_ld;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h04;
    @(posedge clk);
    #1;
    bus.funct3 = 3'b000; bus.addr = 32'h08;
    second_acc = 1'b0; pulses = 0; acc_cycle = 0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.resp_valid) begin
        pulses++;
        if (pulses == 1) begin
          check("t6 resp1_cycle", 32'(c), 32'd2);
          check("t6 resp1_data", bus.load_data, exp1);
        end else begin
          check("t6 resp2_cycle", 32'(c), 32'd5);
          check("t6 resp2_data", bus.load_data, exp2);
        end
      end
      acc_now = !second_acc && bus.req_ready;
      @(posedge clk);
      #1;
      if (acc_now) begin
        second_acc = 1'b1; acc_cycle = c; bus.req_valid = 1'b0;
      end
    end
    check("t6 pulses", 32'(pulses), 32'd2);
    check("t6 accept_cycle", 32'(acc_cycle), 32'd3);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      logic        rw;
      logic [2:0]  f3;
      logic [31:0] a, d;
      int          sel;
      rw  = 1'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel < 8) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = rw ? 3'b000 : 3'b100;
          default: f3 = rw ? 3'b001 : 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom);
      end
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       a = 32'($urandom_range(0, 127));
      else if (sel == 8) a = $urandom;
      else               a = 32'($urandom_range(128, 255));
      if ($urandom_range(0, 9) < 7) a = a & ~((32'h1 << f3[1:0]) - 32'h1);
      d = $urandom;
      run_op($sformatf("rnd%0d", n), rw, f3, a, d, ld, er);
    end

    for (int i = 0; i < WORDS; i++) check($sformatf("final word%0d", i), mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
